// File: rtl/snake_frame_sched.sv
// snake_frame_sched: builds one display frame per accepted frame_start. It clears the
//   matrix decoder, streams every snake body cell from the coordinate RAM into it, then
//   adds the food cell.
// Latency: CLEAR starts 1 cycle after frame_start. Body entry k is on dec_in at T+3+k,
//   food is at T+3+len and frame_done at T+4+len. All outputs are registered.
// Backpressure: none. The decoder and RAM accept one item per cycle. frame_start is
//   only sampled in IDLE.
//
// Ports:
//   clk, rst           - clock; asynchronous active-high reset
//   frame_start        - request a frame (IDLE only)
//   body_len           - body cell count, latched on an accepted frame_start
//   body_addr/body_rd  - RAM read port; body_data returns 1 cycle after body_rd
//   body_data          - body cell coordinate {col[7:4], row[3:0]}
//   food_valid/pos     - food presence and coordinate
//   dec_clr/in/valid   - matrix decoder clear, coordinate and strobe
//   busy, frame_done   - busy from CLEAR through DONE; one-cycle completion pulse
//
// Build option FOOD_BLINK_EN: when defined, a parity bit flips at every frame_done.
//   Food is drawn only on frames where that parity is 0, so the food blinks.

module snake_frame_sched (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic [7:0] body_len,
    output logic [7:0] body_addr,
    output logic       body_rd,
    input  logic [7:0] body_data,
    input  logic       food_valid,
    input  logic [7:0] food_pos,
    output logic       dec_clr,
    output logic [7:0] dec_in,
    output logic       dec_valid,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_BODY,
        S_FOOD,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] len_q, len_d;
    logic       clr_ph_q, clr_ph_d;   // second CLEAR cycle when set
    logic [7:0] ent_q, ent_d;         // body entries already presented
    logic [7:0] addr_q, addr_d;
    logic       rd_q, rd_d;
    logic       clr_q, clr_d;
    logic [7:0] dec_in_q, dec_in_d;
    logic       dec_vld_q, dec_vld_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       food_en;

`ifdef FOOD_BLINK_EN
    logic parity_q, parity_d;

    assign food_en  = food_valid & ~parity_q;
    assign parity_d = (state_q == S_FOOD) ? ~parity_q : parity_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`else
    assign food_en = food_valid;
`endif

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        clr_ph_d  = clr_ph_q;
        ent_d     = ent_q;
        addr_d    = addr_q;
        rd_d      = rd_q;
        dec_in_d  = dec_in_q;
        dec_vld_d = 1'b0;

        // The read engine runs ahead of the decoder by two cycles. It stops after
        // address len-1 and holds that address, so the address never wraps.
        if (rd_q) begin
            if (addr_q == len_q - 8'd1) begin
                rd_d = 1'b0;
            end else begin
                addr_d = addr_q + 8'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d  = S_CLEAR;
                    len_d    = body_len;
                    clr_ph_d = 1'b0;
                    addr_d   = 8'd0;
                    rd_d     = (body_len != 8'd0);
                end
            end
            S_CLEAR: begin
                if (!clr_ph_q) begin
                    clr_ph_d = 1'b1;
                end else if (len_q != 8'd0) begin
                    // The entry 0 read issued on the first CLEAR cycle has returned.
                    state_d   = S_BODY;
                    dec_in_d  = body_data;
                    dec_vld_d = 1'b1;
                    ent_d     = 8'd1;
                end else begin
                    state_d = S_FOOD;
                end
            end
            S_BODY: begin
                if (ent_q == len_q) begin
                    state_d = S_FOOD;
                end else begin
                    dec_in_d  = body_data;
                    dec_vld_d = 1'b1;
                    ent_d     = ent_q + 8'd1;
                end
            end
            S_FOOD:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so food is loaded on the edge that enters FOOD.
        if (state_d == S_FOOD && state_q != S_FOOD && food_en) begin
            dec_in_d  = food_pos;
            dec_vld_d = 1'b1;
        end
    end

    assign busy_d = (state_d != S_IDLE);
    assign clr_d  = (state_d == S_CLEAR);
    assign done_d = (state_d == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            len_q     <= 8'd0;
            clr_ph_q  <= 1'b0;
            ent_q     <= 8'd0;
            addr_q    <= 8'd0;
            rd_q      <= 1'b0;
            clr_q     <= 1'b0;
            dec_in_q  <= 8'h00;
            dec_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            clr_ph_q  <= clr_ph_d;
            ent_q     <= ent_d;
            addr_q    <= addr_d;
            rd_q      <= rd_d;
            clr_q     <= clr_d;
            dec_in_q  <= dec_in_d;
            dec_vld_q <= dec_vld_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign body_addr  = addr_q;
    assign body_rd    = rd_q;
    assign dec_clr    = clr_q;
    assign dec_in     = dec_in_q;
    assign dec_valid  = dec_vld_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_snake_frame_sched.sv
module tb_snake_frame_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_start = 1'b0;
    logic [7:0] body_len = 8'd0;
    logic [7:0] body_addr;
    logic       body_rd;
    logic [7:0] body_data = 8'd0;
    logic       food_valid = 1'b0;
    logic [7:0] food_pos = 8'd0;
    logic       dec_clr;
    logic [7:0] dec_in;
    logic       dec_valid;
    logic       busy;
    logic       frame_done;

`ifdef FOOD_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    snake_frame_sched dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .body_len   (body_len),
        .body_addr  (body_addr),
        .body_rd    (body_rd),
        .body_data  (body_data),
        .food_valid (food_valid),
        .food_pos   (food_pos),
        .dec_clr    (dec_clr),
        .dec_in     (dec_in),
        .dec_valid  (dec_valid),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Body coordinate RAM: data appears one cycle after the read strobe.
    logic [7:0] mem [0:255];
    always @(posedge clk) begin
        if (body_rd) body_data <= mem[body_addr];
    end

    int         n_cmp = 0;
    int         n_bad = 0;
    int         frames_done = 0;   // completed frames since the last reset
    logic [7:0] last_dec = 8'h00;  // value the decoder input must currently hold
    int         food_writes = 0;

    // Model of one frame at cycle-offset level relative to the accepted frame_start.
    // The DUT must be in IDLE when this is called. With keep=1, frame_start stays high.
    task automatic run_frame(input int len, input bit fv, input logic [7:0] fp, input bit keep);
        bit         food_exp;
        logic [4:0] exp_ctrl;
        logic [4:0] act_ctrl;
        food_exp    = fv && (!BLINK || (frames_done % 2 == 0));
        body_len    = len[7:0];
        food_valid  = fv;
        food_pos    = fp;
        frame_start = 1'b1;
        for (int o = 1; o <= len + 5; o++) begin
            @(posedge clk);
            #1;
            if (!keep) frame_start = 1'b0;
            if (o == 1) body_len = 8'($urandom);   // late body_len changes must not matter
            if (o >= 3 && o < 3 + len) begin
                last_dec = mem[o - 3];
            end else if (o == 3 + len && food_exp) begin
                last_dec = fp;
                food_writes++;
            end
            exp_ctrl = {(o <= 2),
                        (len > 0 && o <= len),
                        ((o >= 3 && o < 3 + len) || (o == 3 + len && food_exp)),
                        (o <= len + 4),
                        (o == len + 4)};
            act_ctrl = {dec_clr, body_rd, dec_valid, busy, frame_done};
            n_cmp++;
            if (act_ctrl !== exp_ctrl) begin
                n_bad++;
                $display("FAIL ctrl len=%0d off=%0d {clr,rd,vld,busy,done} got %b exp %b",
                         len, o, act_ctrl, exp_ctrl);
            end
            n_cmp++;
            if (dec_in !== last_dec) begin
                n_bad++;
                $display("FAIL dec_in len=%0d off=%0d got %h exp %h", len, o, dec_in, last_dec);
            end
            if (len > 0 && o <= len) begin
                n_cmp++;
                if (body_addr !== 8'(o - 1)) begin
                    n_bad++;
                    $display("FAIL body_addr len=%0d off=%0d got %0d exp %0d",
                             len, o, body_addr, o - 1);
                end
            end
            if (o == len + 4) frames_done++;
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({body_addr, body_rd, dec_clr, dec_in, dec_valid, busy, frame_done} !== 21'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got addr=%h rd=%b clr=%b in=%h vld=%b busy=%b done=%b exp all 0",
                     body_addr, body_rd, dec_clr, dec_in, dec_valid, busy, frame_done);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        frames_done = 0;
        last_dec = 8'h00;
    endtask

    task automatic test_directed_basic();
        mem[0] = 8'h12;
        mem[1] = 8'h13;
        mem[2] = 8'h14;
        run_frame(3, 1'b1, 8'h5A, 1'b0);
    endtask

    task automatic test_empty_frame();
        run_frame(0, 1'b0, 8'h33, 1'b0);
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 8; f++) begin
            fill_mem();
            if (f == 2) mem[1] = mem[0];   // duplicate coordinate
            run_frame(int'($urandom_range(0, 40)), 1'($urandom), 8'($urandom), 1'b0);
            repeat (int'($urandom_range(0, 2))) @(posedge clk);
            #0;
        end
    endtask

    task automatic test_back_to_back();
        fill_mem();
        run_frame(2, 1'b1, 8'hA1, 1'b1);
        run_frame(5, 1'b1, 8'hA2, 1'b1);
        run_frame(1, 1'b0, 8'hA3, 1'b0);
    endtask

    task automatic test_reset_mid();
        fill_mem();
        body_len    = 8'd10;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({dec_valid, dec_in} !== {1'b1, mem[1]}) begin
            n_bad++;
            $display("FAIL mid_entry1 got vld=%b in=%h exp vld=1 in=%h", dec_valid, dec_in, mem[1]);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({body_addr, body_rd, dec_clr, dec_in, dec_valid, frame_done} !== 20'd0) begin
            n_bad++;
            $display("FAIL mid_reset_outputs got addr=%h rd=%b clr=%b in=%h vld=%b done=%b exp all 0",
                     body_addr, body_rd, dec_clr, dec_in, dec_valid, frame_done);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_busy got %b exp 0", busy);
        end
        frames_done = 0;
        last_dec    = 8'h00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_frame(10, 1'b1, 8'h3C, 1'b0);
    endtask

    task automatic test_food_blink();
        int start_writes;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        frames_done = 0;
        last_dec = 8'h00;
        start_writes = food_writes;
        for (int f = 0; f < 4; f++) begin
            fill_mem();
            run_frame(int'($urandom_range(0, 6)), 1'b1, 8'h77, 1'b0);
        end
        n_cmp++;
        if (food_writes - start_writes !== (BLINK ? 2 : 4)) begin
            n_bad++;
            $display("FAIL blink_count got %0d exp %0d", food_writes - start_writes, BLINK ? 2 : 4);
        end
    endtask

    task automatic test_long_frame();
        fill_mem();
        run_frame(255, 1'b1, 8'hEE, 1'b0);
    endtask

    initial begin
        fill_mem();
        test_reset();
        test_directed_basic();
        test_empty_frame();
        test_random_frames();
        test_back_to_back();
        test_reset_mid();
        test_food_blink();
        test_long_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
